// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - RV32I instruction fetch unit with SRAM request pipeline and fetch queue
module ifu_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] ins_a,
  output logic        ins_e,
  input  logic [31:0] ins,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] branch_pc,
  output logic        ifu_vld,
  output logic [15:0] ifu_pc,
  output logic [31:0] ifu_ins
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   pc;
  logic          req_vld;
  logic [15:0]   req_pc;
  logic [15:0]   fq_pc  [FQ_DEPTH];
  logic [31:0]   fq_ins [FQ_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [15:0]   last_pc;
  logic [31:0]   last_ins;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ_next;
  logic          unused_bpc;

  // Low address bits of the redirect target are dropped; instructions are word aligned.
  assign unused_bpc = ^branch_pc[1:0];

  assign ifu_vld = (cnt != '0);
  assign pop     = ifu_vld & ~stall;
  // A returning word is only kept if no redirect kills it in the same cycle.
  assign push    = req_vld & ~branch;

  // Occupancy after this cycle's pop plus the word already in flight; issuing only
  // when it stays below depth leaves room for the word this request returns.
  assign occ_next = {1'b0, cnt} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, req_vld};

  assign ins_e   = issue;
  assign ins_a   = pc;
  assign ifu_pc  = ifu_vld ? fq_pc[rptr]  : last_pc;
  assign ifu_ins = ifu_vld ? fq_ins[rptr] : last_ins;

  // Next-state and issue decision.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        issue = ~branch & (occ_next < DEPTH_C);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; only reset brings the unit back to IDLE.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch pc and in-flight request tracking; a redirect overrides sequential issue.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pc      <= RESET_PC;
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else begin
      req_vld <= issue;
      if (issue) begin
        req_pc <= pc;
      end
      if (branch) begin
        pc <= {branch_pc[15:2], 2'b00};
      end else if (issue) begin
        pc <= pc + 16'd4;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (branch) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Queue storage: returning SRAM word tagged with the pc that requested it.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[wptr]  <= req_pc;
      fq_ins[wptr] <= ins;
    end
  end

  // Remember the last consumed entry so the outputs hold while the queue is empty.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      last_pc  <= '0;
      last_ins <= '0;
    end else if (pop) begin
      last_pc  <= fq_pc[rptr];
      last_ins <= fq_ins[rptr];
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table, directed sequences, random vs queue model
module tb_ifu_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins;
  logic        stall;
  logic        branch;
  logic [15:0] branch_pc;
  logic        ifu_vld;
  logic [15:0] ifu_pc;
  logic [31:0] ifu_ins;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];

  ifu_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ins_a     (ins_a),
    .ins_e     (ins_e),
    .ins       (ins),
    .stall     (stall),
    .branch    (branch),
    .branch_pc (branch_pc),
    .ifu_vld   (ifu_vld),
    .ifu_pc    (ifu_pc),
    .ifu_ins   (ifu_ins)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: address/enable registered, data valid the next cycle.
  always @(posedge clk) begin
    if (ins_e) ins <= mem[ins_a[9:2]];
  end

  // Reference model: fetch queue of pcs, one optional in-flight pc.
  logic [15:0] m_q[$];
  bit          m_inf;
  logic [15:0] m_inf_pc;
  logic [15:0] m_pc;
  bit          m_run;
  logic [15:0] m_last_pc;
  logic [31:0] m_last_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    int occ;
    int pop;
    pop = (m_q.size() != 0 && !stall) ? 1 : 0;
    occ = m_q.size() - pop + (m_inf ? 1 : 0);
    return m_run && !branch && (occ < DEPTH);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inf      = 0;
    m_inf_pc   = '0;
    m_pc       = RESET_PC;
    m_run      = 0;
    m_last_pc  = '0;
    m_last_ins = '0;
  endtask

  task automatic model_check();
    bit e;
    if (rstn) begin
      chk("rst_vld", {31'b0, ifu_vld}, 32'd0);
      chk("rst_ins_e", {31'b0, ins_e}, 32'd0);
      chk("rst_pc", {16'b0, ifu_pc}, 32'd0);
      chk("rst_ins", ifu_ins, 32'd0);
      chk("rst_ins_a", {16'b0, ins_a}, {16'b0, RESET_PC});
    end else begin
      chk("vld", {31'b0, ifu_vld}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("pc", {16'b0, ifu_pc}, {16'b0, m_q[0]});
        chk("ins", ifu_ins, mem[m_q[0][9:2]]);
      end else begin
        chk("hold_pc", {16'b0, ifu_pc}, {16'b0, m_last_pc});
        chk("hold_ins", ifu_ins, m_last_ins);
      end
      e = m_issue();
      chk("ins_e", {31'b0, ins_e}, {31'b0, e});
      if (e) chk("ins_a", {16'b0, ins_a}, {16'b0, m_pc});
    end
  endtask

  task automatic model_step();
    bit iss;
    if (rstn) begin
      model_reset();
    end else begin
      iss = m_issue();
      if (m_q.size() != 0 && !stall) begin
        m_last_pc  = m_q[0];
        m_last_ins = mem[m_q[0][9:2]];
        void'(m_q.pop_front());
      end
      if (m_inf && !branch) m_q.push_back(m_inf_pc);
      if (branch) begin
        m_q.delete();
        m_pc  = {branch_pc[15:2], 2'b00};
        m_inf = 0;
      end else begin
        m_inf = iss;
        if (iss) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 16'd4;
        end
      end
      m_run = 1;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] bpc);
    @(negedge clk);
    rstn      = r;
    stall     = s;
    branch    = b;
    branch_pc = bpc;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  // Redirect, then the target must appear exactly three cycles after the branch cycle.
  task automatic branch_seq(input logic [15:0] bpc, input logic st, input logic [15:0] tgt);
    drive(1'b0, st, 1'b1, bpc);
    chk("br_ins_e", {31'b0, ins_e}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("br_p1_vld", {31'b0, ifu_vld}, 32'd0);
    chk("br_p1_ins_e", {31'b0, ins_e}, 32'd1);
    chk("br_p1_ins_a", {16'b0, ins_a}, {16'b0, tgt});
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("br_p2_vld", {31'b0, ifu_vld}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("br_p3_vld", {31'b0, ifu_vld}, 32'd1);
    chk("br_p3_pc", {16'b0, ifu_pc}, {16'b0, tgt});
    tick();
  endtask

  typedef struct {
    logic        stall;
    logic        exp_vld;
    logic [15:0] exp_pc;
    logic        exp_ie;
  } vec_t;

  vec_t tbl[12];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    ins       = '0;
    rstn      = 1'b1;
    stall     = 1'b0;
    branch    = 1'b0;
    branch_pc = '0;
    model_reset();

    // Reset state.
    repeat (3) tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    tick();

    // Release, stream three words, then stall five cycles starting at first ifu_vld.
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 16'h0004, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 16'h0008, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 16'h000C, 1'b1};
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].stall, 1'b0, 16'h0);
      chk($sformatf("tbl%0d_vld", i), {31'b0, ifu_vld}, {31'b0, tbl[i].exp_vld});
      chk($sformatf("tbl%0d_pc", i), {16'b0, ifu_pc}, {16'b0, tbl[i].exp_pc});
      chk($sformatf("tbl%0d_ins_e", i), {31'b0, ins_e}, {31'b0, tbl[i].exp_ie});
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_ins", i), ifu_ins, mem[tbl[i].exp_pc[9:2]]);
      tick();
    end

    // Redirect while streaming; target 0x0042 aligns to 0x0040.
    branch_seq(16'h0042, 1'b0, 16'h0040);
    repeat (3) begin drive(1'b0, 1'b0, 1'b0, 16'h0); tick(); end

    // Fill the queue with stall, then redirect under stall.
    repeat (3) begin drive(1'b0, 1'b1, 1'b0, 16'h0); tick(); end
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    chk("full_vld", {31'b0, ifu_vld}, 32'd1);
    chk("full_ins_e", {31'b0, ins_e}, 32'd0);
    tick();
    branch_seq(16'h0100, 1'b1, 16'h0100);

    // Back-to-back redirects: the last one wins.
    drive(1'b0, 1'b0, 1'b1, 16'h0200);
    tick();
    branch_seq(16'h0300, 1'b0, 16'h0300);

    // Address wrap at the top of the 16-bit space.
    branch_seq(16'hFFF8, 1'b0, 16'hFFF8);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("wrap_pc1", {16'b0, ifu_pc}, 32'h0000_FFFC);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("wrap_pc2", {16'b0, ifu_pc}, 32'h0000_0000);
    chk("wrap_vld2", {31'b0, ifu_vld}, 32'd1);
    tick();

    // Mid-stream reset with the queue full: outputs drop immediately.
    repeat (3) begin drive(1'b0, 1'b1, 1'b0, 16'h0); tick(); end
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    chk("mrst_vld", {31'b0, ifu_vld}, 32'd0);
    chk("mrst_ins_e", {31'b0, ins_e}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      if (c == 1) chk("mrst_restart_a", {16'b0, ins_a}, {16'b0, RESET_PC});
      if (c == 3) chk("mrst_restart_pc", {16'b0, ifu_pc}, {16'b0, RESET_PC});
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), 16'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
